mac4_row_accumulator: RTL and testbench
=======================================

Name: mac4_row_accumulator

Overview:
- Downstream consumer of the 4-lane Q4.12 multiply-accumulate stage.
- Sums a sequence of 4-element partial dot products, one per accepted beat, into a wide accumulator, so that one full matrix-row × vector product is built for the LSTM gate computation.
- Adds the row bias at the start of a row.
- Saturates the final sum to Q4.12 and presents it on a valid/ready output to the activation stage.

Parameters:
- DATA_WIDTH, 16, width of partial sums, bias and result (Q4.12).
- ACC_WIDTH, 24, internal accumulator width (Q12.12); must be > DATA_WIDTH.
- CNT_WIDTH, 8, width of the chunk counter; maximum 2^CNT_WIDTH-1 chunks per row.

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Asynchronous, active-high reset.
- start  in  1  Begin a new row. Sampled only in IDLE.
- num_chunks  in  CNT_WIDTH  Number of partial sums in the row. Sampled with start.
- bias  in  DATA_WIDTH  Signed Q4.12 row bias. Sampled with start.
- psum_valid  in  1  Partial sum available from the MAC stage.
- psum_ready  out  1  Block accepts psum this cycle.
- psum  in  DATA_WIDTH  Signed Q4.12 partial sum, the MAC stage result.
- out_valid  out  1  Row result available.
- out_ready  in  1  Downstream accepts the result.
- out_data  out  DATA_WIDTH  Saturated signed Q4.12 row result.
- out_sat  out  1  Set if out_data was clipped. Valid while out_valid is high.
- busy  out  1  High in ACCUM or DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE; acc=0; count=0.
  - All outputs 0: psum_ready, out_valid, out_data, out_sat, busy.
  - Reset asserted mid-row discards the row; no output is produced.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - psum_ready=0; out_valid=0.
  - On start=1: acc <= sign-extended bias; count <= num_chunks.
  - Next state is ACCUM, or DONE directly if num_chunks==0. In that case the result is the bias and out_sat=0.
- ACCUM:
  - psum_ready=1 combinationally, with no bubbles; one psum can be accepted every cycle.
  - On psum_valid & psum_ready: acc <= acc + sign_extend(psum); count <= count-1.
  - When the beat with count==1 is accepted, go to DONE. The final sum is computed from that beat included.
  - psum_valid low: hold state; no accumulation.
- Saturation is applied once, on entry to DONE, and out_data/out_sat are registered:
  - acc > 32767 → out_data=0x7FFF, out_sat=1.
  - acc < -32768 → out_data=0x8000, out_sat=1.
  - Otherwise out_data=acc[DATA_WIDTH-1:0], out_sat=0.
- The accumulator itself does not wrap for num_chunks ≤ 255 at ACC_WIDTH=24. No intermediate saturation.
- Latency: out_valid rises in the cycle after the last psum handshake, or 1 cycle after start when num_chunks==0.
- DONE:
  - out_valid=1; psum_ready=0.
  - out_data and out_sat are held stable until out_ready=1.
  - On out_valid & out_ready: go to IDLE, out_valid=0.
  - out_data keeps its last value; out_sat is cleared.
- start while busy is ignored, with no state change.
- start in IDLE in the same cycle as the DONE→IDLE return is not possible. The earliest new start is the cycle after the handshake, so the back-to-back row gap is 1 cycle.
- busy = (state != IDLE).
- Arithmetic is signed two's-complement throughout. psum and bias are both Q4.12; no shifting in this block.

Test Plan:
- Basic row:
  - Stimulus: bias=0x0800 (0.5), num_chunks=3, psums 0x1000, 0x1000, 0xF000 on consecutive cycles, out_ready=1.
  - Required: out_data=0x1800 (1.5), out_sat=0, out_valid for exactly 1 cycle, 1 cycle after the 3rd beat.
- Gaps and backpressure:
  - Stimulus: the same row with psum_valid toggling 1,0,1,0,1, and out_ready held 0 for 4 cycles.
  - Required: the same 0x1800; out_valid and out_data are stable while stalled; busy=1 throughout; return to IDLE on the handshake.
- Saturation:
  - Stimulus: bias=0x7000, 4 psums of 0x7000. Then a second row with bias=0x8000 and 2 psums of 0x9000.
  - Required: first result 0x7FFF, out_sat=1. Second result 0x8000, out_sat=1.
- Zero-length row:
  - Stimulus: num_chunks=0, bias=0xFC00.
  - Required: out_valid 1 cycle after start; out_data=0xFC00; out_sat=0; psum_ready never asserted.
- Start while busy:
  - Stimulus: start pulsed during ACCUM with different bias/num_chunks.
  - Required: ignored; the original row result is unchanged.
- Mid-row reset:
  - Stimulus: rst asserted asynchronously after 2 of 5 beats.
  - Required: all outputs 0 immediately. A new row of 1 psum 0x0400 with bias 0 then yields 0x0400.

Source files
------------

// File: rtl/mac4_row_accumulator.sv
// Row accumulator behind the 4-lane Q4.12 MAC stage. It sums a row bias and
// num_chunks partial sums, then presents the Q4.12-saturated result on valid/ready.
module mac4_row_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_chunks,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic                  psum_valid,
  output logic                  psum_ready,
  input  logic [DATA_WIDTH-1:0] psum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sat,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Returns {clipped, value}; the sum fits Q4.12 when every bit above the
  // result sign bit matches the accumulator sign.
  function automatic logic [DATA_WIDTH:0] saturate(input logic [ACC_WIDTH-1:0] a);
    logic [DATA_WIDTH:0] r;
    if (a[ACC_WIDTH-1:DATA_WIDTH-1] == {(ACC_WIDTH-DATA_WIDTH+1){a[ACC_WIDTH-1]}}) begin
      r = {1'b0, a[DATA_WIDTH-1:0]};
    end else if (a[ACC_WIDTH-1]) begin
      r = {1'b1, SAT_MIN};
    end else begin
      r = {1'b1, SAT_MAX};
    end
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic [ACC_WIDTH-1:0]    sum_s;
  logic [DATA_WIDTH:0]     sat_s;

  assign sum_s = acc_q + {{(ACC_WIDTH-DATA_WIDTH){psum[DATA_WIDTH-1]}}, psum};
  assign sat_s = saturate(sum_s);

  // Next-state and datapath update for the row sequencer.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = {{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
          count_d = num_chunks;
          if (num_chunks == CNT_ZERO) begin
            state_d    = ST_DONE;
            out_data_d = bias;
            out_sat_d  = 1'b0;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (psum_valid) begin
          acc_d   = sum_s;
          count_d = count_q - CNT_ONE;
          if (count_q == CNT_ONE) begin
            state_d    = ST_DONE;
            out_data_d = sat_s[DATA_WIDTH-1:0];
            out_sat_d  = sat_s[DATA_WIDTH];
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d   = ST_IDLE;
          out_sat_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= {ACC_WIDTH{1'b0}};
      count_q    <= {CNT_WIDTH{1'b0}};
      out_data_q <= {DATA_WIDTH{1'b0}};
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign psum_ready = (state_q == ST_ACCUM);
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign out_data   = out_data_q;
  assign out_sat    = out_sat_q;

endmodule

// File: tb/tb_mac4_row_accumulator.sv
// Directed self-checking bench for mac4_row_accumulator with hand-computed results.
module tb_mac4_row_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  num_chunks;
  logic [15:0] bias;
  logic        psum_valid;
  logic        psum_ready;
  logic [15:0] psum;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        busy;

  int checks;
  int errors;

  mac4_row_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_chunks (num_chunks),
    .bias       (bias),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum       (psum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_row(input logic [15:0] b, input logic [7:0] n);
    start      = 1'b1;
    bias       = b;
    num_chunks = n;
    step();
    start      = 1'b0;
    bias       = 16'h0000;
    num_chunks = 8'd0;
  endtask

  task automatic feed(input logic v, input logic [15:0] d);
    psum_valid = v;
    psum       = d;
    step();
    psum_valid = 1'b0;
    psum       = 16'h0000;
  endtask

  task automatic check_result(input string tag, input logic [15:0] d, input logic s);
    check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_val({tag, "_data"}, {16'd0, out_data}, {16'd0, d});
    check_val({tag, "_sat"}, {31'd0, out_sat}, {31'd0, s});
    check_val({tag, "_pready"}, {31'd0, psum_ready}, 32'd0);
  endtask

  initial begin
    logic [15:0] gap_data [5];
    logic        gap_vld  [5];
    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; num_chunks = 8'd0; bias = 16'h0000;
    psum_valid = 1'b0; psum = 16'h0000; out_ready = 1'b1;
    #12;
    check_val("rst_pready", {31'd0, psum_ready}, 32'd0);
    check_val("rst_ovalid", {31'd0, out_valid}, 32'd0);
    check_val("rst_odata", {16'd0, out_data}, 32'd0);
    check_val("rst_osat", {31'd0, out_sat}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // basic row: 0.5 + 1 + 1 - 1 = 1.5
    start_row(16'h0800, 8'd3);
    check_val("basic_pready", {31'd0, psum_ready}, 32'd1);
    check_val("basic_busy", {31'd0, busy}, 32'd1);
    feed(1'b1, 16'h1000);
    check_val("basic_novalid1", {31'd0, out_valid}, 32'd0);
    feed(1'b1, 16'h1000);
    check_val("basic_novalid2", {31'd0, out_valid}, 32'd0);
    feed(1'b1, 16'hF000);
    check_result("basic", 16'h1800, 1'b0);
    step();
    check_val("basic_onecycle", {31'd0, out_valid}, 32'd0);
    check_val("basic_idle", {31'd0, busy}, 32'd0);
    check_val("basic_hold_data", {16'd0, out_data}, 32'h1800);

    // gaps and backpressure
    gap_vld  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    gap_data = '{16'h1000, 16'h5555, 16'h1000, 16'h5555, 16'hF000};
    out_ready = 1'b0;
    start_row(16'h0800, 8'd3);
    for (int i = 0; i < 5; i++) begin
      check_val("gap_busy", {31'd0, busy}, 32'd1);
      check_val("gap_novalid", {31'd0, out_valid}, 32'd0);
      feed(gap_vld[i], gap_data[i]);
    end
    for (int i = 0; i < 4; i++) begin
      check_result("stall", 16'h1800, 1'b0);
      check_val("stall_busy", {31'd0, busy}, 32'd1);
      step();
    end
    out_ready = 1'b1;
    check_result("stall_end", 16'h1800, 1'b0);
    step();
    check_val("gap_idle", {31'd0, busy}, 32'd0);
    check_val("gap_ovalid", {31'd0, out_valid}, 32'd0);

    // positive saturation: 5 * 0x7000 = 0x23000
    start_row(16'h7000, 8'd4);
    for (int i = 0; i < 4; i++) feed(1'b1, 16'h7000);
    check_result("satpos", 16'h7FFF, 1'b1);
    step();
    check_val("satpos_clr", {31'd0, out_sat}, 32'd0);
    check_val("satpos_keep", {16'd0, out_data}, 32'h7FFF);

    // negative saturation: -32768 + 2 * -28672
    start_row(16'h8000, 8'd2);
    feed(1'b1, 16'h9000);
    feed(1'b1, 16'h9000);
    check_result("satneg", 16'h8000, 1'b1);
    step();

    // negative in-range sum: -1.0 + -0.5 = 0xE800, no clipping
    start_row(16'hF000, 8'd1);
    feed(1'b1, 16'hF800);
    check_result("neg_inrange", 16'hE800, 1'b0);
    step();

    // zero-length row
    check_val("zero_pready_pre", {31'd0, psum_ready}, 32'd0);
    start_row(16'hFC00, 8'd0);
    check_result("zero", 16'hFC00, 1'b0);
    step();
    check_val("zero_idle", {31'd0, busy}, 32'd0);

    // start while busy: 0x0100 * 3 = 0x0300
    start_row(16'h0100, 8'd2);
    feed(1'b1, 16'h0100);
    start = 1'b1; bias = 16'h4000; num_chunks = 8'd5;
    step();
    start = 1'b0; bias = 16'h0000; num_chunks = 8'd0;
    check_val("busystart_accum", {31'd0, psum_ready}, 32'd1);
    feed(1'b1, 16'h0100);
    check_result("busystart", 16'h0300, 1'b0);
    step();

    // mid-row asynchronous reset
    start_row(16'h0000, 8'd5);
    feed(1'b1, 16'h1000);
    feed(1'b1, 16'h1000);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_pready", {31'd0, psum_ready}, 32'd0);
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_val("midrst_odata", {16'd0, out_data}, 32'd0);
    check_val("midrst_ovalid", {31'd0, out_valid}, 32'd0);
    step();
    rst = 1'b0;
    step();
    start_row(16'h0000, 8'd1);
    feed(1'b1, 16'h0400);
    check_result("postrst", 16'h0400, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
